// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: time-multiplexed scan controller for a 4-digit
// 7-segment display. It generates the digit selector, the active-low anode
// drives, the current digit nibble and its decimal point. It has a guard
// interval that prevents ghosting, per-digit blanking and 16-level PWM
// brightness.
// New values arrive on a valid/ready port and are held in a shadow register.
// They are committed to the displayed value only at a frame boundary.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading zero
// digits (3..1) of the displayed value are dark.
module display_scan_scheduler #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int CW           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  brightness,
  output logic [1:0]  selector,
  output logic [3:0]  digit,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LEN = CW'(GUARD_CYCLES);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   active_q, active_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic          wr_ready_q, wr_ready_d;
  logic [3:0]    an_n_q, an_n_d;
  logic          dp_n_q, dp_n_d;
  logic [3:0]    digit_q, digit_d;
  logic          fd_q, fd_d;
  logic          guard, on_phase, blanked;
  logic [3:0]    auto_blank;

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] s);
    logic [3:0] n;
    case (s)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  // Next-state logic. All outputs are computed from the next counter and
  // selector values, so each registered output lines up with the slot_cnt it
  // describes.
  always_comb begin
    slot_cnt_d  = slot_cnt_q + CW'(1);
    sel_d       = sel_q;
    active_d    = active_q;
    act_dp_d    = act_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      sel_d      = sel_q + 2'd1;
    end

    // The commit happens only on the frame_done cycle, so a frame never mixes
    // two values. A write accepted on that same cycle sees pending_q=0 and
    // therefore waits for the next frame boundary.
    if (fd_q && pending_q) begin
      active_d  = shadow_q;
      act_dp_d  = shadow_dp_q;
      pending_d = 1'b0;
    end else if (wr_valid && wr_ready_q) begin
      shadow_d    = wr_data;
      shadow_dp_d = wr_dp;
      pending_d   = 1'b1;
    end
    wr_ready_d = !pending_d;

`ifdef LEADING_ZERO_BLANK_EN
    auto_blank = lz_mask(active_d);
`else
    auto_blank = 4'b0000;
`endif

    guard    = (slot_cnt_d < GUARD_LEN);
    on_phase = !guard && (slot_cnt_d[3:0] <= brightness);
    blanked  = blank_mask[sel_d] || auto_blank[sel_d];

    an_n_d  = (on_phase && !blanked) ? ~(4'b0001 << sel_d) : 4'b1111;
    dp_n_d  = (guard || blanked) ? 1'b1 : ~act_dp_d[sel_d];
    digit_d = nibble(active_d, sel_d);
    fd_d    = (slot_cnt_d == SLOT_LAST) && (sel_d == 2'd3);
  end

  // Registers for the state and for all outputs. An asynchronous reset drops
  // any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      sel_q       <= 2'd0;
      active_q    <= 16'h0000;
      act_dp_q    <= 4'b0000;
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'b0000;
      pending_q   <= 1'b0;
      wr_ready_q  <= 1'b1;
      an_n_q      <= 4'b1111;
      dp_n_q      <= 1'b1;
      digit_q     <= 4'd0;
      fd_q        <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      sel_q       <= sel_d;
      active_q    <= active_d;
      act_dp_q    <= act_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      wr_ready_q  <= wr_ready_d;
      an_n_q      <= an_n_d;
      dp_n_q      <= dp_n_d;
      digit_q     <= digit_d;
      fd_q        <= fd_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign selector   = sel_q;
  assign digit      = digit_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule
